// File: rtl/a_74194.sv
// a_74194: 74194-style universal shift register.
// Each edge holds, shifts right, shifts left or loads; clr clears at once.
module a_74194 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             M1,
  input  logic             M0,
  input  logic             SR,
  input  logic             SL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_nxt;

  // Right shift moves data toward Q[WIDTH-1]; left shift toward Q[0].
  always_comb begin
    q_nxt = Q;
    unique case ({M1, M0})
      2'b00: q_nxt = Q;
      2'b01: q_nxt = {Q[WIDTH-2:0], SR};
      2'b10: q_nxt = {SL, Q[WIDTH-1:1]};
      2'b11: q_nxt = D;
      default: q_nxt = Q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) Q <= '0;
    else     Q <= q_nxt;
  end

endmodule

// File: tb/tb_a_74194.sv
// tb_a_74194: directed checks of the 74194-style shift register.
// Inputs move 1ns after rising edges; Q is sampled 1ns after them.
module tb_a_74194;

  logic       clk;
  logic       clr;
  logic       M1, M0, SR, SL;
  logic [3:0] D;
  logic [3:0] Q;

  int checks = 0;
  int errors = 0;

  a_74194 #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .M1(M1), .M0(M0),
    .SR(SR), .SL(SL), .D(D), .Q(Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; M1 = 1'b1; M0 = 1'b1; D = 4'b1100;
    SR = 1'b0; SL = 1'b0;
    #1;
    checks++;
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: Q=%b expected 0000", Q);
    end
    edge1();
    edge1();
    checks++;
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held: Q=%b expected 0000", Q);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: Q=%b expected 0000", Q);
    end
  endtask

  task automatic test_load();
    M1 = 1'b1; M0 = 1'b1; D = 4'b1100;
    edge1();
    checks++;
    if (Q !== 4'b1100) begin
      errors++;
      $display("FAIL load: Q=%b expected 1100", Q);
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] exp [8];
    exp = '{4'b1001, 4'b0011, 4'b0111, 4'b1111,
            4'b1110, 4'b1100, 4'b1000, 4'b0000};
    M1 = 1'b0; M0 = 1'b1; SL = 1'b0; D = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      SR = (i < 4);
      edge1();
      checks++;
      if (Q !== exp[i]) begin
        errors++;
        $display("FAIL shift_right[%0d]: Q=%b expected %b", i, Q, exp[i]);
      end
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp [8];
    exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
            4'b0111, 4'b0011, 4'b0001, 4'b0000};
    M1 = 1'b1; M0 = 1'b0; SR = 1'b1; D = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      SL = (i < 4);
      edge1();
      checks++;
      if (Q !== exp[i]) begin
        errors++;
        $display("FAIL shift_left[%0d]: Q=%b expected %b", i, Q, exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    M1 = 1'b1; M0 = 1'b1; D = 4'b1010;
    edge1();
    checks++;
    if (Q !== 4'b1010) begin
      errors++;
      $display("FAIL hold_load: Q=%b expected 1010", Q);
    end
    M1 = 1'b0; M0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      SR = i[0];
      SL = ~i[0];
      D  = 4'(i * 5 + 3);
      edge1();
      checks++;
      if (Q !== 4'b1010) begin
        errors++;
        $display("FAIL hold[%0d]: Q=%b expected 1010", i, Q);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    M1 = 1'b1; M0 = 1'b1; D = 4'b0110;
    edge1();
    M1 = 1'b0; M0 = 1'b1; SR = 1'b1;
    edge1();
    checks++;
    if (Q !== 4'b1101) begin
      errors++;
      $display("FAIL mid_pre: Q=%b expected 1101", Q);
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL mid_clear: Q=%b expected 0000", Q);
    end
    edge1();
    checks++;
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL mid_clear_edge: Q=%b expected 0000", Q);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL mid_release: Q=%b expected 0000", Q);
    end
    edge1();
    checks++;
    if (Q !== 4'b0001) begin
      errors++;
      $display("FAIL mid_resume: Q=%b expected 0001", Q);
    end
  endtask

  task automatic test_back_to_back();
    M1 = 1'b1; M0 = 1'b1; D = 4'b1001;
    edge1();
    M1 = 1'b1; M0 = 1'b0; SL = 1'b0;
    edge1();
    checks++;
    if (Q !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_left: Q=%b expected 0100", Q);
    end
    M1 = 1'b0; M0 = 1'b1; SR = 1'b1;
    edge1();
    checks++;
    if (Q !== 4'b1001) begin
      errors++;
      $display("FAIL b2b_right: Q=%b expected 1001", Q);
    end
    M1 = 1'b1; M0 = 1'b1; D = 4'b0111;
    edge1();
    checks++;
    if (Q !== 4'b0111) begin
      errors++;
      $display("FAIL b2b_load: Q=%b expected 0111", Q);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left();
    test_hold();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
